w5300_parallel_if: RTL
======================

# w5300_parallel_if

Bus engine between `w5300_udp_conf_comm` and the W5300 pins. It executes one 16-bit register access per command received on the intraconnect ports (`caddr`, `wr_data`, `rd_data`, `op_status`). It drives the W5300 direct-address parallel bus (10-bit address, 16-bit data) with parameterised setup, strobe and hold timing. It also generates the W5300 hardware reset and PLL-lock wait after system reset.

## Interface
Parameters:
- `CLK_FREQ`, 100: clock frequency in MHz; scales the reset counters.
- `RST_LOW_US`, 2: W5300 `nRESET` low time in µs.
- `RST_WAIT_US`, 10000: wait after `nRESET` release, in µs, before accepting commands.
- `SETUP_CYC`, 1: address/data setup cycles before the strobe. Range 1–15.
- `STROBE_CYC`, 7: cycles with `cs_n` and `rd_n`/`wr_n` low. Range 1–15.
- `HOLD_CYC`, 1: cycles after the strobe with address/data held. Range 1–15.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `caddr` in 12: command. Bit 11 = 1 means invalid (no command); bit 10 = 1 means read, 0 means write; bits [9:0] are the W5300 address.
- `wr_data` in 16: write data, captured with the command.
- `rd_data` out 16: data from the last completed read.
- `op_status` out 1: one-cycle pulse when an access completes.
- `init_done` out 1: high once the W5300 reset sequence has finished.
- `w5300_rst_n` out 1: W5300 `nRESET`.
- `w5300_cs_n`, `w5300_rd_n`, `w5300_wr_n` out 1 each: bus strobes, active-low.
- `w5300_addr` out 10: W5300 `ADDR[9:0]`.
- `w5300_data` inout 16: W5300 `DATA[15:0]`. Tri-stated when the block is not driving it.

## Operation
- FSM states: `S_RST_LOW`, `S_RST_WAIT`, `S_IDLE`, `S_SETUP`, `S_STROBE`, `S_HOLD`, `S_DONE`.
- Every output is registered.
- Reset values:
  - `w5300_rst_n` = 0
  - `w5300_cs_n`, `w5300_rd_n`, `w5300_wr_n` = 1
  - `w5300_addr` = 0
  - `w5300_data` = Z
  - `rd_data` = 0
  - `op_status` = 0
  - `init_done` = 0
  - state = `S_RST_LOW`
- `S_RST_LOW`: hold `w5300_rst_n` low for `CLK_FREQ*RST_LOW_US` cycles, then go to `S_RST_WAIT` and drive `w5300_rst_n` high.
- `S_RST_WAIT`: count `CLK_FREQ*RST_WAIT_US` cycles, then go to `S_IDLE` and set `init_done` = 1.
  - Counter width is at least 24 bits.
  - `caddr` is ignored in both reset states: no capture, no `op_status`.
- `S_IDLE`: on a clock edge with `caddr[11]` = 0, latch `caddr[10:0]` and `wr_data`, then enter `S_SETUP`. With `caddr[11]` = 1, stay idle.
- `S_SETUP` (`SETUP_CYC` cycles): drive `w5300_addr`. For a write, also drive `w5300_data` with the latched data. Strobes stay high.
- `S_STROBE` (`STROBE_CYC` cycles): `w5300_cs_n` = 0, plus `w5300_rd_n` = 0 (read) or `w5300_wr_n` = 0 (write).
  - Read: on the edge that ends the last strobe cycle, `rd_data` takes `w5300_data`.
- `S_HOLD` (`HOLD_CYC` cycles): all strobes high. Address held; write data still driven.
- `S_DONE` (1 cycle): `op_status` = 1, data bus released to Z. Next state is `S_IDLE`.
- `rd_data` is unchanged by writes and holds its value until the next read completes.
- The upstream block must update or invalidate `caddr` on the edge that samples `op_status` = 1. A `caddr` left valid is re-executed.
- `w5300_data` is driven only during `S_SETUP` through `S_HOLD` of a write. It is never driven during a read.

## Timing
- Accept edge = edge A (in `S_IDLE`, `caddr[11]` = 0).
- `w5300_cs_n` is low from cycle `A+SETUP_CYC+1` for exactly `STROBE_CYC` cycles.
- `op_status` is high in cycle `A+SETUP_CYC+STROBE_CYC+HOLD_CYC+1`.
  - Defaults: cycle A+10.
- Back-to-back accesses: the next command can be accepted 2 edges after the `op_status` edge.
  - Defaults: 11 cycles per access.
- Strobe counters reload at each state entry. State transition happens when count = param−1.
- `rst_n` asserted mid-access:
  - Strobes deassert and the bus goes to Z asynchronously.
  - `op_status` stays 0.
  - The full reset sequence restarts.

## Test plan
- Init, with `CLK_FREQ`=1, `RST_LOW_US`=3, `RST_WAIT_US`=5:
  - `w5300_rst_n` is low for 3 cycles after reset release.
  - `init_done` rises 5 cycles later.
  - A valid `caddr`=12'h0FE presented during init causes no strobe and no `op_status`.
- Write, defaults: `caddr`=12'h002, `wr_data`=16'hA5C3 →
  - `w5300_addr`=10'h002 and data=A5C3 from A+1 to A+9.
  - `cs_n` and `wr_n` low A+2..A+8; `rd_n` stays high.
  - `op_status` pulses at A+10, then the bus goes to Z.
- Read: `caddr`=12'h4FE, W5300 model returns 16'h5300 →
  - `rd_n` low 7 cycles.
  - `rd_data`=16'h5300 from the last strobe edge onward.
  - Block never drives the data bus.
  - A following write leaves `rd_data`=16'h5300.
- Back-to-back: read 0x200 then write 0x202 with `caddr` changed on the `op_status` edge →
  - Exactly 2 accesses and 2 `op_status` pulses, 11 cycles apart.
  - Strobes high between the accesses.
- Idle: `caddr`=12'h800 held for 100 cycles → no strobe activity and `op_status` stays 0.
- `rst_n` low during `S_STROBE` of a write →
  - Strobes go high and data goes to Z immediately, with no `op_status`.
  - `w5300_rst_n` goes low and the init sequence repeats.

Source files
------------

// File: rtl/w5300_parallel_if.sv
// W5300 direct-address parallel bus engine: one 16-bit register access per command,
// plus the W5300 hardware reset pulse and PLL-lock wait after system reset.
//
// state      | meaning
// S_RST_LOW  | nRESET held low to the W5300
// S_RST_WAIT | nRESET released, waiting for the W5300 PLL to lock
// S_IDLE     | waiting for a valid command on caddr
// S_SETUP    | address (and write data) driven, strobes high
// S_STROBE   | cs_n and rd_n/wr_n low
// S_HOLD     | strobes high, address and write data still held
// S_DONE     | op_status pulse, data bus released
module w5300_parallel_if #(
    parameter int unsigned CLK_FREQ    = 100,
    parameter int unsigned RST_LOW_US  = 2,
    parameter int unsigned RST_WAIT_US = 10000,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 7,
    parameter int unsigned HOLD_CYC    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] caddr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_status,
    output logic        init_done,
    output logic        w5300_rst_n,
    output logic        w5300_cs_n,
    output logic        w5300_rd_n,
    output logic        w5300_wr_n,
    output logic [9:0]  w5300_addr,
    inout  wire  [15:0] w5300_data
);

    localparam int unsigned RST_LOW_CYC  = CLK_FREQ * RST_LOW_US;
    localparam int unsigned RST_WAIT_CYC = CLK_FREQ * RST_WAIT_US;

    localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYC - 1);
    localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYC - 1);
    localparam logic [3:0]  SETUP_LAST    = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  STROBE_LAST   = 4'(STROBE_CYC - 1);
    localparam logic [3:0]  HOLD_LAST     = 4'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15 || RST_LOW_CYC < 1 || RST_WAIT_CYC < 1) begin : g_param_check
        $error("w5300_parallel_if: phase lengths must be 1..15 and reset times non-zero");
    end

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] rst_cnt;
    logic [3:0]  ph_cnt;
    logic        is_rd;
    logic        data_oe;
    logic [15:0] wdata_q;

    // data_oe is cleared by the async reset, so an aborted write releases the bus at once
    assign w5300_data = data_oe ? wdata_q : 16'hzzzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RST_LOW;
            rst_cnt     <= '0;
            ph_cnt      <= '0;
            is_rd       <= 1'b0;
            data_oe     <= 1'b0;
            wdata_q     <= '0;
            rd_data     <= '0;
            op_status   <= 1'b0;
            init_done   <= 1'b0;
            w5300_rst_n <= 1'b0;
            w5300_cs_n  <= 1'b1;
            w5300_rd_n  <= 1'b1;
            w5300_wr_n  <= 1'b1;
            w5300_addr  <= '0;
        end else begin
            case (state)
                S_RST_LOW: begin
                    if (rst_cnt == RST_LOW_LAST) begin
                        rst_cnt     <= '0;
                        w5300_rst_n <= 1'b1;
                        state       <= S_RST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 32'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (rst_cnt == RST_WAIT_LAST) begin
                        rst_cnt   <= '0;
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (!caddr[11]) begin
                        is_rd      <= caddr[10];
                        w5300_addr <= caddr[9:0];
                        wdata_q    <= wr_data;
                        data_oe    <= ~caddr[10];
                        ph_cnt     <= '0;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        ph_cnt     <= '0;
                        w5300_cs_n <= 1'b0;
                        w5300_rd_n <= ~is_rd;
                        w5300_wr_n <= is_rd;
                        state      <= S_STROBE;
                    end else begin
                        ph_cnt <= ph_cnt + 4'd1;
                    end
                end
                S_STROBE: begin
                    if (ph_cnt == STROBE_LAST) begin
                        ph_cnt     <= '0;
                        w5300_cs_n <= 1'b1;
                        w5300_rd_n <= 1'b1;
                        w5300_wr_n <= 1'b1;
                        if (is_rd) begin
                            rd_data <= w5300_data;
                        end
                        state <= S_HOLD;
                    end else begin
                        ph_cnt <= ph_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (ph_cnt == HOLD_LAST) begin
                        ph_cnt    <= '0;
                        data_oe   <= 1'b0;
                        op_status <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        ph_cnt <= ph_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    op_status <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_RST_LOW;
                end
            endcase
        end
    end

endmodule
